// File: rtl/regfile_server.sv
// regfile_server: ARF/PRF storage with a per-preg ready scoreboard.
// Reads are combinational and see same-cycle writeback and commit traffic
// through bypass, so the source stage never waits on a storage write.

// One read lane: resolves one ARF address and one PRF address against
// storage plus the same-cycle writeback and commit bypass paths.
module regfile_server_rd #(
    parameter int AREG_NUM     = 32,
    parameter int PREG_NUM     = 64,
    parameter int XLEN         = 64,
    parameter int WB_PORTS     = 4,
    parameter int COMMIT_PORTS = 4,
    parameter int AW           = $clog2(AREG_NUM),
    parameter int PW           = $clog2(PREG_NUM)
) (
    input  logic [AW-1:0]                        src,
    input  logic [PW-1:0]                        psrc,
    input  logic [AREG_NUM-1:0][XLEN-1:0]        arf_q,
    input  logic [PREG_NUM-1:0][XLEN-1:0]        prf_q,
    input  logic [PREG_NUM-1:0]                  rdy_q,
    input  logic [WB_PORTS-1:0]                  wb_valid,
    input  logic [WB_PORTS-1:0][PW-1:0]          wb_pdst,
    input  logic [WB_PORTS-1:0][XLEN-1:0]        wb_data,
    input  logic [COMMIT_PORTS-1:0]              commit_valid,
    input  logic [COMMIT_PORTS-1:0][AW-1:0]      commit_dst,
    input  logic [COMMIT_PORTS-1:0][XLEN-1:0]    commit_val,
    output logic [XLEN-1:0]                      arf_o,
    output logic [XLEN-1:0]                      prf_o,
    output logic                                 rdy_o
);

    // ARF read: storage, overridden by the youngest same-cycle commit; areg 0 is zero.
    always_comb begin
        arf_o = arf_q[src];
        for (int k = 0; k < COMMIT_PORTS; k++) begin
            if (commit_valid[k] && (commit_dst[k] == src))
                arf_o = commit_val[k];
        end
        if (src == '0)
            arf_o = '0;
    end

    // PRF/ready read: storage, overridden by the highest same-cycle writeback hit.
    always_comb begin
        prf_o = prf_q[psrc];
        rdy_o = rdy_q[psrc];
        for (int j = 0; j < WB_PORTS; j++) begin
            if (wb_valid[j] && (wb_pdst[j] == psrc)) begin
                prf_o = wb_data[j];
                rdy_o = 1'b1;
            end
        end
    end

endmodule

// Top: storage, write arbitration and one read lane per source operand.
module regfile_server #(
    parameter int AREG_READ_PORTS = 8,
    parameter int WB_PORTS        = 4,
    parameter int COMMIT_PORTS    = 4,
    parameter int ALLOC_PORTS     = 4,
    parameter int AREG_NUM        = 32,
    parameter int PREG_NUM        = 64,
    parameter int XLEN            = 64,
    parameter int AW              = $clog2(AREG_NUM),
    parameter int PW              = $clog2(PREG_NUM)
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [AREG_READ_PORTS-1:0][AW-1:0]      src1,
    input  logic [AREG_READ_PORTS-1:0][AW-1:0]      src2,
    input  logic [AREG_READ_PORTS-1:0][PW-1:0]      psrc1,
    input  logic [AREG_READ_PORTS-1:0][PW-1:0]      psrc2,
    output logic [AREG_READ_PORTS-1:0][XLEN-1:0]    arf1,
    output logic [AREG_READ_PORTS-1:0][XLEN-1:0]    arf2,
    output logic [AREG_READ_PORTS-1:0][XLEN-1:0]    prf1,
    output logic [AREG_READ_PORTS-1:0][XLEN-1:0]    prf2,
    output logic [AREG_READ_PORTS-1:0]              rdy1,
    output logic [AREG_READ_PORTS-1:0]              rdy2,
    input  logic [WB_PORTS-1:0]                     wb_valid,
    input  logic [WB_PORTS-1:0][PW-1:0]             wb_pdst,
    input  logic [WB_PORTS-1:0][XLEN-1:0]           wb_data,
    input  logic [COMMIT_PORTS-1:0]                 commit_valid,
    input  logic [COMMIT_PORTS-1:0][AW-1:0]         commit_dst,
    input  logic [COMMIT_PORTS-1:0][PW-1:0]         commit_pdst,
    input  logic [ALLOC_PORTS-1:0]                  alloc_valid,
    input  logic [ALLOC_PORTS-1:0][PW-1:0]          alloc_pdst,
    input  logic                                    flush
);

    logic [AREG_NUM-1:0][XLEN-1:0]     arf_q;
    logic [PREG_NUM-1:0][XLEN-1:0]     prf_q;
    logic [PREG_NUM-1:0]               rdy_q;
    logic [COMMIT_PORTS-1:0][XLEN-1:0] commit_val;

    // Value each commit port retires: its preg after same-cycle writeback bypass.
    always_comb begin
        for (int k = 0; k < COMMIT_PORTS; k++) begin
            commit_val[k] = prf_q[commit_pdst[k]];
            for (int j = 0; j < WB_PORTS; j++) begin
                if (wb_valid[j] && (wb_pdst[j] == commit_pdst[k]))
                    commit_val[k] = wb_data[j];
            end
        end
    end

    // PRF writeback; later NBAs win, so the highest port takes a shared pdst.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prf_q <= '0;
        end else begin
            for (int j = 0; j < WB_PORTS; j++) begin
                if (wb_valid[j])
                    prf_q[wb_pdst[j]] <= wb_data[j];
            end
        end
    end

    // ARF retire; the youngest port wins a shared dst, areg 0 is never written.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arf_q <= '0;
        end else begin
            for (int k = 0; k < COMMIT_PORTS; k++) begin
                if (commit_valid[k] && (commit_dst[k] != '0))
                    arf_q[commit_dst[k]] <= commit_val[k];
            end
        end
    end

    // Ready scoreboard: wb sets, alloc clears (beating wb), flush sets all
    // and suppresses alloc.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q <= '1;
        end else begin
            for (int j = 0; j < WB_PORTS; j++) begin
                if (wb_valid[j])
                    rdy_q[wb_pdst[j]] <= 1'b1;
            end
            if (!flush) begin
                for (int m = 0; m < ALLOC_PORTS; m++) begin
                    if (alloc_valid[m])
                        rdy_q[alloc_pdst[m]] <= 1'b0;
                end
            end else begin
                rdy_q <= '1;
            end
        end
    end

    // Two read lanes per read port: operand 1 and operand 2.
    for (genvar i = 0; i < AREG_READ_PORTS; i++) begin : g_rd
        regfile_server_rd #(
            .AREG_NUM(AREG_NUM), .PREG_NUM(PREG_NUM), .XLEN(XLEN),
            .WB_PORTS(WB_PORTS), .COMMIT_PORTS(COMMIT_PORTS),
            .AW(AW), .PW(PW)
        ) u_rd1 (
            .src(src1[i]), .psrc(psrc1[i]),
            .arf_q(arf_q), .prf_q(prf_q), .rdy_q(rdy_q),
            .wb_valid(wb_valid), .wb_pdst(wb_pdst), .wb_data(wb_data),
            .commit_valid(commit_valid), .commit_dst(commit_dst),
            .commit_val(commit_val),
            .arf_o(arf1[i]), .prf_o(prf1[i]), .rdy_o(rdy1[i])
        );
        regfile_server_rd #(
            .AREG_NUM(AREG_NUM), .PREG_NUM(PREG_NUM), .XLEN(XLEN),
            .WB_PORTS(WB_PORTS), .COMMIT_PORTS(COMMIT_PORTS),
            .AW(AW), .PW(PW)
        ) u_rd2 (
            .src(src2[i]), .psrc(psrc2[i]),
            .arf_q(arf_q), .prf_q(prf_q), .rdy_q(rdy_q),
            .wb_valid(wb_valid), .wb_pdst(wb_pdst), .wb_data(wb_data),
            .commit_valid(commit_valid), .commit_dst(commit_dst),
            .commit_val(commit_val),
            .arf_o(arf2[i]), .prf_o(prf2[i]), .rdy_o(rdy2[i])
        );
    end

endmodule

// File: tb/tb_regfile_server.sv
// Directed bench for regfile_server: bypass, arbitration, scoreboard, reset.
module tb_regfile_server;

    localparam int RP = 8, WB = 4, CP = 4, AP = 4, XLEN = 64;

    logic clk = 1'b0;
    logic resetn;
    logic [RP-1:0][4:0]      src1, src2;
    logic [RP-1:0][5:0]      psrc1, psrc2;
    logic [RP-1:0][XLEN-1:0] arf1, arf2, prf1, prf2;
    logic [RP-1:0]           rdy1, rdy2;
    logic [WB-1:0]           wb_valid;
    logic [WB-1:0][5:0]      wb_pdst;
    logic [WB-1:0][XLEN-1:0] wb_data;
    logic [CP-1:0]           commit_valid;
    logic [CP-1:0][4:0]      commit_dst;
    logic [CP-1:0][5:0]      commit_pdst;
    logic [AP-1:0]           alloc_valid;
    logic [AP-1:0][5:0]      alloc_pdst;
    logic                    flush;

    int checks = 0;
    int errors = 0;

    regfile_server dut (
        .clk(clk), .resetn(resetn),
        .src1(src1), .src2(src2), .psrc1(psrc1), .psrc2(psrc2),
        .arf1(arf1), .arf2(arf2), .prf1(prf1), .prf2(prf2),
        .rdy1(rdy1), .rdy2(rdy2),
        .wb_valid(wb_valid), .wb_pdst(wb_pdst), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_dst(commit_dst), .commit_pdst(commit_pdst),
        .alloc_valid(alloc_valid), .alloc_pdst(alloc_pdst), .flush(flush)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = '0; wb_pdst = '0; wb_data = '0;
        commit_valid = '0; commit_dst = '0; commit_pdst = '0;
        alloc_valid = '0; alloc_pdst = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        src2 = '0; psrc2 = '0;
        for (int i = 0; i < RP; i++) begin
            src1[i] = 5'd5;
            psrc1[i] = 6'd9;
        end
        resetn = 1'b0;
        #12;
        for (int i = 0; i < RP; i++) begin
            checks++;
            if (arf1[i] !== 64'h0 || prf1[i] !== 64'h0 || rdy1[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_read port %0d: arf1=%h prf1=%h rdy1=%b, want 0 0 1",
                         i, arf1[i], prf1[i], rdy1[i]);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_wb_bypass();
        wb_valid[0] = 1'b1; wb_pdst[0] = 6'd9; wb_data[0] = 64'hDEAD;
        @(negedge clk);
        checks++;
        if (prf1[3] !== 64'hDEAD) begin
            errors++; $display("FAIL wb_bypass_data: got %h want dead", prf1[3]);
        end
        checks++;
        if (rdy1[3] !== 1'b1) begin
            errors++; $display("FAIL wb_bypass_rdy: got %b want 1", rdy1[3]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (prf1[3] !== 64'hDEAD) begin
            errors++; $display("FAIL wb_stored: got %h want dead", prf1[3]);
        end
        tick();
    endtask

    task automatic test_wb_priority();
        psrc2[0] = 6'd30;
        wb_valid[0] = 1'b1; wb_pdst[0] = 6'd30; wb_data[0] = 64'h1;
        wb_valid[2] = 1'b1; wb_pdst[2] = 6'd30; wb_data[2] = 64'h2;
        @(negedge clk);
        checks++;
        if (prf2[0] !== 64'h2) begin
            errors++; $display("FAIL wb_prio_bypass: got %h want 2", prf2[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (prf2[0] !== 64'h2) begin
            errors++; $display("FAIL wb_prio_stored: got %h want 2", prf2[0]);
        end
        tick();
    endtask

    task automatic test_alloc_flush();
        psrc1[0] = 6'd12;
        psrc1[1] = 6'd13;
        alloc_valid[0] = 1'b1; alloc_pdst[0] = 6'd12;
        wb_valid[1] = 1'b1; wb_pdst[1] = 6'd12; wb_data[1] = 64'h55;
        @(negedge clk);
        checks++;
        if (rdy1[0] !== 1'b1 || prf1[0] !== 64'h55) begin
            errors++; $display("FAIL alloc_wb_same_cycle: rdy=%b prf=%h want 1 55", rdy1[0], prf1[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rdy1[0] !== 1'b0) begin
            errors++; $display("FAIL alloc_beats_wb_rdy: got %b want 0", rdy1[0]);
        end
        checks++;
        if (prf1[0] !== 64'h55) begin
            errors++; $display("FAIL alloc_wb_data: got %h want 55", prf1[0]);
        end
        tick();
        // flush with a competing alloc on 13: alloc must be dropped
        flush = 1'b1;
        alloc_valid[1] = 1'b1; alloc_pdst[1] = 6'd13;
        @(negedge clk);
        checks++;
        if (rdy1[0] !== 1'b0) begin
            errors++; $display("FAIL flush_not_bypassed: got %b want 0", rdy1[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rdy1[0] !== 1'b1) begin
            errors++; $display("FAIL flush_sets_ready: got %b want 1", rdy1[0]);
        end
        checks++;
        if (rdy1[1] !== 1'b1) begin
            errors++; $display("FAIL flush_drops_alloc: got %b want 1", rdy1[1]);
        end
        tick();
    endtask

    task automatic test_commit();
        wb_valid[0] = 1'b1; wb_pdst[0] = 6'd21; wb_data[0] = 64'h99;
        tick();
        idle();
        src2[0] = 5'd7;
        src2[1] = 5'd8;
        wb_valid[0] = 1'b1; wb_pdst[0] = 6'd20; wb_data[0] = 64'h1234;
        commit_valid[0] = 1'b1; commit_dst[0] = 5'd7; commit_pdst[0] = 6'd20;
        commit_valid[1] = 1'b1; commit_dst[1] = 5'd7; commit_pdst[1] = 6'd21;
        commit_valid[2] = 1'b1; commit_dst[2] = 5'd8; commit_pdst[2] = 6'd20;
        @(negedge clk);
        checks++;
        if (arf2[0] !== 64'h99) begin
            errors++; $display("FAIL commit_youngest_bypass: got %h want 99", arf2[0]);
        end
        checks++;
        if (arf2[1] !== 64'h1234) begin
            errors++; $display("FAIL commit_wb_bypass: got %h want 1234", arf2[1]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (arf2[0] !== 64'h99) begin
            errors++; $display("FAIL commit_youngest_stored: got %h want 99", arf2[0]);
        end
        checks++;
        if (arf2[1] !== 64'h1234) begin
            errors++; $display("FAIL commit_wb_stored: got %h want 1234", arf2[1]);
        end
        tick();
    endtask

    task automatic test_commit_zero();
        src1[0] = 5'd0;
        commit_valid[0] = 1'b1; commit_dst[0] = 5'd0; commit_pdst[0] = 6'd20;
        @(negedge clk);
        checks++;
        if (arf1[0] !== 64'h0) begin
            errors++; $display("FAIL commit_zero_bypass: got %h want 0", arf1[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (arf1[0] !== 64'h0) begin
            errors++; $display("FAIL commit_zero_stored: got %h want 0", arf1[0]);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        alloc_valid[0] = 1'b1; alloc_pdst[0] = 6'd50;
        tick();
        idle();
        src1[0] = 5'd7; psrc1[0] = 6'd12; psrc1[1] = 6'd50; psrc1[2] = 6'd40;
        src1[1] = 5'd9;
        @(negedge clk);
        checks++;
        if (rdy1[1] !== 1'b0 || arf1[0] !== 64'h99) begin
            errors++; $display("FAIL pre_reset_state: rdy50=%b arf7=%h want 0 99", rdy1[1], arf1[0]);
        end
        wb_valid[0] = 1'b1; wb_pdst[0] = 6'd40; wb_data[0] = 64'hAAAA;
        commit_valid[0] = 1'b1; commit_dst[0] = 5'd9; commit_pdst[0] = 6'd40;
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (arf1[0] !== 64'h0 || prf1[0] !== 64'h0 || rdy1[1] !== 1'b1) begin
            errors++; $display("FAIL mid_reset_reads: arf7=%h prf12=%h rdy50=%b want 0 0 1",
                               arf1[0], prf1[0], rdy1[1]);
        end
        tick();
        idle();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (prf1[2] !== 64'h0 || arf1[1] !== 64'h0 || arf1[0] !== 64'h0) begin
            errors++; $display("FAIL post_reset_no_write: prf40=%h arf9=%h arf7=%h want 0 0 0",
                               prf1[2], arf1[1], arf1[0]);
        end
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_wb_priority();
        test_alloc_flush();
        test_commit();
        test_commit_zero();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
